// File: rtl/array_memory_pkg.sv
// Shared definitions for the array memory sequencer/arbiter.
package array_memory_pkg;

  typedef enum logic [1:0] {
    S_SCAN = 2'd0,
    S_HOST = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_REG_NUM   = 8;
  localparam int DEF_ADDR_BITS = 3;
  localparam int DEF_DWELL     = 1000;

  // True when a zero-extended address selects an existing memory location.
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] limit);
    return (addr < limit);
  endfunction

endpackage

// File: rtl/array_memory_ctrl_scan_counter.sv
// Dwell counter and scan index for the background display scanner.
// index_next is the value scan_index takes on the coming edge, so the
// parent can register a memory address that lines up with scan_index.
module scan_counter #(
  parameter int REG_NUM   = 8,
  parameter int ADDR_BITS = 3,
  parameter int DWELL     = 1000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 advance,
  output logic [ADDR_BITS-1:0] scan_index,
  output logic [ADDR_BITS-1:0] index_next
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]        DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0]        DWELL_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] INDEX_LAST = ADDR_BITS'(REG_NUM - 1);
  localparam logic [ADDR_BITS-1:0] INDEX_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  logic [CW-1:0] dwell_cnt;
  logic [CW-1:0] dwell_next;

  // Next dwell/index: step only when advancing, wrap index at REG_NUM-1.
  always_comb begin
    dwell_next = dwell_cnt;
    index_next = scan_index;
    if (advance) begin
      if (dwell_cnt == DWELL_LAST) begin
        dwell_next = {CW{1'b0}};
        if (scan_index == INDEX_LAST) begin
          index_next = {ADDR_BITS{1'b0}};
        end else begin
          index_next = scan_index + INDEX_ONE;
        end
      end else begin
        dwell_next = dwell_cnt + DWELL_ONE;
        index_next = scan_index;
      end
    end else begin
      dwell_next = dwell_cnt;
      index_next = scan_index;
    end
  end

  // Counter state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dwell_cnt  <= {CW{1'b0}};
      scan_index <= {ADDR_BITS{1'b0}};
    end else begin
      dwell_cnt  <= dwell_next;
      scan_index <= index_next;
    end
  end

endmodule

// File: rtl/array_memory_ctrl.sv
// Arbiter between the display scanner and the host port for the 8x4 array
// memory. All memory control lines and handshake outputs are registered.
module array_memory_ctrl
  import array_memory_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int REG_NUM   = DEF_REG_NUM,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DWELL     = DEF_DWELL
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 scan_en,
  input  logic                 host_req,
  input  logic                 host_rw,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic [WIDTH-1:0]     host_data,
  output logic                 host_ack,
  output logic                 host_err,
  output logic                 busy,
  output logic [ADDR_BITS-1:0] scan_index,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic                 mem_rw,
  output logic                 mem_ensure,
  output logic [WIDTH-1:0]     mem_data_in
);

  localparam logic [31:0] REG_LIMIT = REG_NUM;

  state_t                 state;
  logic                   cap_err;
  logic                   advance;
  logic                   in_range;
  logic [ADDR_BITS-1:0]   index_next;

  // The scanner only steps in S_SCAN and never on an edge that accepts the host.
  assign advance  = scan_en && (state == S_SCAN) && !host_req;
  assign in_range = addr_in_range({{(32-ADDR_BITS){1'b0}}, host_addr}, REG_LIMIT);

  scan_counter #(
    .REG_NUM   (REG_NUM),
    .ADDR_BITS (ADDR_BITS),
    .DWELL     (DWELL)
  ) u_scan_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .advance    (advance),
    .scan_index (scan_index),
    .index_next (index_next)
  );

  // Sequencer FSM with registered memory controls and host handshake.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_SCAN;
      cap_err     <= 1'b0;
      host_ack    <= 1'b0;
      host_err    <= 1'b0;
      busy        <= 1'b0;
      mem_address <= {ADDR_BITS{1'b0}};
      mem_rw      <= RW_READ;
      mem_ensure  <= 1'b0;
      mem_data_in <= {WIDTH{1'b0}};
    end else begin
      case (state)
        S_SCAN: begin
          host_ack <= 1'b0;
          host_err <= 1'b0;
          if (host_req) begin
            state       <= S_HOST;
            cap_err     <= !in_range;
            busy        <= 1'b1;
            mem_address <= host_addr;
            mem_rw      <= host_rw;
            mem_data_in <= host_data;
            mem_ensure  <= in_range;
          end else begin
            state       <= S_SCAN;
            busy        <= 1'b0;
            mem_address <= index_next;
            mem_rw      <= RW_READ;
            mem_ensure  <= scan_en;
          end
        end
        S_HOST: begin
          state       <= S_ACK;
          host_ack    <= 1'b1;
          host_err    <= cap_err;
          busy        <= 1'b1;
          mem_address <= scan_index;
          mem_rw      <= RW_READ;
          mem_ensure  <= scan_en;
        end
        S_ACK: begin
          state       <= S_SCAN;
          host_ack    <= 1'b0;
          host_err    <= 1'b0;
          busy        <= 1'b0;
          mem_address <= scan_index;
          mem_rw      <= RW_READ;
          mem_ensure  <= scan_en;
        end
        default: begin
          state       <= S_SCAN;
          cap_err     <= 1'b0;
          host_ack    <= 1'b0;
          host_err    <= 1'b0;
          busy        <= 1'b0;
          mem_address <= scan_index;
          mem_rw      <= RW_READ;
          mem_ensure  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_array_memory_ctrl.sv
// Directed, table-driven bench for array_memory_ctrl (DWELL=4).
// dut_a uses REG_NUM=8, dut_b uses REG_NUM=6 for the out-of-range case.
module tb_array_memory_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       scan_en;
  logic       host_req;
  logic       host_rw;
  logic [2:0] host_addr;
  logic [3:0] host_data;

  logic       a_ack, a_err, a_busy, a_rw, a_ens;
  logic [2:0] a_idx, a_addr;
  logic [3:0] a_din;
  logic       b_ack, b_err, b_busy, b_rw, b_ens;
  logic [2:0] b_idx, b_addr;
  logic [3:0] b_din;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  array_memory_ctrl #(.WIDTH(4), .REG_NUM(8), .ADDR_BITS(3), .DWELL(4)) dut_a (
    .clock(clock), .reset_n(reset_n), .scan_en(scan_en), .host_req(host_req),
    .host_rw(host_rw), .host_addr(host_addr), .host_data(host_data),
    .host_ack(a_ack), .host_err(a_err), .busy(a_busy), .scan_index(a_idx),
    .mem_address(a_addr), .mem_rw(a_rw), .mem_ensure(a_ens), .mem_data_in(a_din)
  );

  array_memory_ctrl #(.WIDTH(4), .REG_NUM(6), .ADDR_BITS(3), .DWELL(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .scan_en(scan_en), .host_req(host_req),
    .host_rw(host_rw), .host_addr(host_addr), .host_data(host_data),
    .host_ack(b_ack), .host_err(b_err), .busy(b_busy), .scan_index(b_idx),
    .mem_address(b_addr), .mem_rw(b_rw), .mem_ensure(b_ens), .mem_data_in(b_din)
  );

  typedef struct {
    logic       req, rw, en;
    logic [2:0] addr;
    logic [3:0] data;
    logic       ack, err, busy;
    logic [2:0] maddr;
    logic       mrw, mens;
    logic [3:0] mdin;
    logic [2:0] idx;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic req, input logic rw, input logic en,
                              input logic [2:0] addr, input logic [3:0] data,
                              input logic ack, input logic err, input logic bsy,
                              input logic [2:0] maddr, input logic mrw, input logic mens,
                              input logic [3:0] mdin, input logic [2:0] idx);
    vec_t v;
    v.req = req; v.rw = rw; v.en = en; v.addr = addr; v.data = data;
    v.ack = ack; v.err = err; v.busy = bsy; v.maddr = maddr;
    v.mrw = mrw; v.mens = mens; v.mdin = mdin; v.idx = idx;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Checks dut_a against the reset values.
  task automatic chk_a_reset(input string tag);
    chk({tag, " ack"},  32'(a_ack),  32'd0);
    chk({tag, " err"},  32'(a_err),  32'd0);
    chk({tag, " busy"}, 32'(a_busy), 32'd0);
    chk({tag, " addr"}, 32'(a_addr), 32'd0);
    chk({tag, " rw"},   32'(a_rw),   32'd1);
    chk({tag, " ens"},  32'(a_ens),  32'd0);
    chk({tag, " din"},  32'(a_din),  32'd0);
    chk({tag, " idx"},  32'(a_idx),  32'd0);
  endtask

  initial begin
    //        req   rw    en    addr  data   ack   err   busy  maddr mrw   mens  mdin   idx
    // write to 1 while scan sits at index 3, dwell 2
    tbl[0]  = mk(1'b1, 1'b0, 1'b1, 3'd1, 4'd4, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 4'd4, 3'd3);
    tbl[1]  = mk(1'b1, 1'b1, 1'b1, 3'd5, 4'd9, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 4'd4, 3'd3);
    tbl[2]  = mk(1'b0, 1'b1, 1'b1, 3'd5, 4'd9, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 4'd4, 3'd3);
    tbl[3]  = mk(1'b0, 1'b1, 1'b1, 3'd5, 4'd9, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 4'd4, 3'd3);
    tbl[4]  = mk(1'b0, 1'b1, 1'b1, 3'd5, 4'd9, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 4'd4, 3'd4);
    // read with req held one cycle too long: two accesses
    tbl[5]  = mk(1'b1, 1'b1, 1'b1, 3'd2, 4'd7, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 4'd7, 3'd4);
    tbl[6]  = mk(1'b1, 1'b1, 1'b1, 3'd2, 4'd7, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 4'd7, 3'd4);
    tbl[7]  = mk(1'b1, 1'b1, 1'b1, 3'd2, 4'd7, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 4'd7, 3'd4);
    tbl[8]  = mk(1'b1, 1'b1, 1'b1, 3'd2, 4'd7, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 4'd7, 3'd4);
    tbl[9]  = mk(1'b0, 1'b1, 1'b1, 3'd2, 4'd7, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 4'd7, 3'd4);
    tbl[10] = mk(1'b0, 1'b1, 1'b1, 3'd2, 4'd7, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 4'd7, 3'd4);
    // read with correct deassertion: one access, then scan resumes
    tbl[11] = mk(1'b1, 1'b1, 1'b1, 3'd6, 4'd3, 1'b0, 1'b0, 1'b1, 3'd6, 1'b1, 1'b1, 4'd3, 3'd4);
    tbl[12] = mk(1'b1, 1'b1, 1'b1, 3'd6, 4'd3, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 4'd3, 3'd4);
    tbl[13] = mk(1'b0, 1'b1, 1'b1, 3'd6, 4'd3, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 4'd3, 3'd4);
    tbl[14] = mk(1'b0, 1'b1, 1'b1, 3'd6, 4'd3, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 4'd3, 3'd4);
    tbl[15] = mk(1'b0, 1'b1, 1'b1, 3'd6, 4'd3, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 4'd3, 3'd4);
    tbl[16] = mk(1'b0, 1'b1, 1'b1, 3'd6, 4'd3, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 4'd3, 3'd4);
    // host write with scanner disabled, arriving when a scan step is due
    tbl[17] = mk(1'b1, 1'b0, 1'b0, 3'd0, 4'hA, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 4'hA, 3'd4);
    tbl[18] = mk(1'b1, 1'b0, 1'b0, 3'd0, 4'hA, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 4'hA, 3'd4);
    tbl[19] = mk(1'b0, 1'b0, 1'b0, 3'd0, 4'hA, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 4'hA, 3'd4);
    tbl[20] = mk(1'b0, 1'b0, 1'b0, 3'd0, 4'hA, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 4'hA, 3'd4);

    // Reset held, then released with the scanner off
    reset_n = 1'b0; scan_en = 1'b0; host_req = 1'b0; host_rw = 1'b1;
    host_addr = 3'd0; host_data = 4'd0;
    step();
    step();
    chk_a_reset("reset");
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk_a_reset($sformatf("idle%0d", c));
    end

    // Scan: 4 cycles per location, wraps 7 -> 0, stops at index 3 dwell 2
    scan_en = 1'b1;
    for (int k = 1; k <= 46; k++) begin
      step();
      chk($sformatf("scan%0d addr", k), 32'(a_addr), 32'((k / 4) % 8));
      chk($sformatf("scan%0d idx", k),  32'(a_idx),  32'((k / 4) % 8));
      chk($sformatf("scan%0d ens", k),  32'(a_ens),  32'd1);
      chk($sformatf("scan%0d rw", k),   32'(a_rw),   32'd1);
    end

    // Table-driven host accesses
    for (int i = 0; i < 21; i++) begin
      host_req = tbl[i].req; host_rw = tbl[i].rw; scan_en = tbl[i].en;
      host_addr = tbl[i].addr; host_data = tbl[i].data;
      step();
      chk($sformatf("row%0d ack", i),  32'(a_ack),  32'(tbl[i].ack));
      chk($sformatf("row%0d err", i),  32'(a_err),  32'(tbl[i].err));
      chk($sformatf("row%0d busy", i), 32'(a_busy), 32'(tbl[i].busy));
      chk($sformatf("row%0d addr", i), 32'(a_addr), 32'(tbl[i].maddr));
      chk($sformatf("row%0d rw", i),   32'(a_rw),   32'(tbl[i].mrw));
      chk($sformatf("row%0d ens", i),  32'(a_ens),  32'(tbl[i].mens));
      chk($sformatf("row%0d din", i),  32'(a_din),  32'(tbl[i].mdin));
      chk($sformatf("row%0d idx", i),  32'(a_idx),  32'(tbl[i].idx));
    end

    // Address 7: out of range for REG_NUM=6, in range for REG_NUM=8
    scan_en = 1'b1; host_req = 1'b1; host_rw = 1'b1; host_addr = 3'd7; host_data = 4'd0;
    step();
    chk("oor host b_ens",  32'(b_ens),  32'd0);
    chk("oor host b_busy", 32'(b_busy), 32'd1);
    chk("oor host b_addr", 32'(b_addr), 32'd7);
    chk("oor host b_ack",  32'(b_ack),  32'd0);
    chk("oor host a_ens",  32'(a_ens),  32'd1);
    step();
    chk("oor ack b_ack", 32'(b_ack), 32'd1);
    chk("oor ack b_err", 32'(b_err), 32'd1);
    chk("oor ack a_ack", 32'(a_ack), 32'd1);
    chk("oor ack a_err", 32'(a_err), 32'd0);
    host_req = 1'b0;
    step();
    chk("oor done b_ack", 32'(b_ack), 32'd0);
    chk("oor done b_err", 32'(b_err), 32'd0);
    chk("oor done a_addr", 32'(a_addr), 32'd4);
    // deferred scan step (dwell was at 3) happens on the first free edge
    step();
    chk("deferred step addr", 32'(a_addr), 32'd5);
    chk("deferred step idx",  32'(a_idx),  32'd5);

    // Reset asserted during S_HOST aborts the access
    host_req = 1'b1; host_rw = 1'b0; host_addr = 3'd2; host_data = 4'd5;
    step();
    chk("abort host busy", 32'(a_busy), 32'd1);
    chk("abort host addr", 32'(a_addr), 32'd2);
    #2;
    reset_n = 1'b0;
    host_req = 1'b0;
    #1;
    chk_a_reset("abort now");
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("abort hold%0d ack", c), 32'(a_ack), 32'd0);
      chk($sformatf("abort hold%0d busy", c), 32'(a_busy), 32'd0);
    end
    reset_n = 1'b1;
    scan_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("restart%0d addr", k), 32'(a_addr), 32'(k / 4));
      chk($sformatf("restart%0d ack", k),  32'(a_ack),  32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
